// File: rtl/tmds_decoder_if.sv
// ============================================================================
// Module      : tmds_decoder_if
// Description : Lane bundle between a 1:10 deserializer and tmds_decoder.
//               Optional loss counter port when TMDS_LOSS_CNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tmds_decoder_if;
   logic [9:0]  tmds_in;
   logic        bitslip_out;
   logic        aligned_out;
   logic [7:0]  data_out;
   logic        de_out;
   logic        c0_out;
   logic        c1_out;
`ifdef TMDS_LOSS_CNT_EN
   logic [15:0] loss_cnt_out;

   modport master (output tmds_in, input bitslip_out, aligned_out, data_out,
                   de_out, c0_out, c1_out, loss_cnt_out);
   modport slave  (input tmds_in, output bitslip_out, aligned_out, data_out,
                   de_out, c0_out, c1_out, loss_cnt_out);
`else
   modport master (output tmds_in, input bitslip_out, aligned_out, data_out,
                   de_out, c0_out, c1_out);
   modport slave  (input tmds_in, output bitslip_out, aligned_out, data_out,
                   de_out, c0_out, c1_out);
`endif
endinterface

`default_nettype wire

// File: rtl/tmds_decoder.sv
// ============================================================================
// Module      : tmds_decoder
// Description : TMDS lane decoder with control-token word alignment and
//               bit-slip hunting. Macro TMDS_LOSS_CNT_EN adds a lock-loss counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tmds_decoder #(
   parameter int CTRL_RUN       = 16,
   parameter int SEARCH_TIMEOUT = 2048,
   parameter int SLIP_SETTLE    = 16
) (
   input  wire logic     clk,
   input  wire logic     rstn,
   tmds_decoder_if.slave bus
);

   localparam int c_RUN_W = $clog2(CTRL_RUN + 1);
   localparam int c_TO_W  = $clog2(SEARCH_TIMEOUT + 1);
   localparam int c_SET_W = $clog2(SLIP_SETTLE + 1);
   localparam logic [c_RUN_W-1:0] c_RUN_LAST = c_RUN_W'(CTRL_RUN - 1);
   localparam logic [c_TO_W-1:0]  c_TO_LAST  = c_TO_W'(SEARCH_TIMEOUT - 1);
   localparam logic [c_SET_W-1:0] c_SET_LAST = c_SET_W'(SLIP_SETTLE - 1);

   typedef enum logic [1:0] {
      ST_SEARCH = 2'd0,
      ST_SLIP   = 2'd1,
      ST_SETTLE = 2'd2,
      ST_LOCKED = 2'd3
   } state_t;

   state_t             r_state;
   logic [c_RUN_W-1:0] r_run_cnt;
   logic [c_TO_W-1:0]  r_to_cnt;
   logic [c_SET_W-1:0] r_set_cnt;
   logic               r_bitslip;
   logic               r_aligned;

   logic [9:0]         r_sym;
   logic               r_tok;
   logic [1:0]         r_tok_c;
   logic               w_tok;
   logic [1:0]         w_tok_c;
   logic [7:0]         w_d;
   logic [7:0]         w_dec;
   logic               w_to_hit;
   logic               w_lock;
   logic               w_unlock;
   logic               w_aligned_nxt;

   logic [7:0]         r_data;
   logic               r_de;
   logic               r_c0;
   logic               r_c1;

   always_comb begin
      w_tok   = 1'b1;
      w_tok_c = 2'b00;
      case (bus.tmds_in)
         10'h354: w_tok_c = 2'b00;
         10'h0AB: w_tok_c = 2'b01;
         10'h154: w_tok_c = 2'b10;
         10'h2AB: w_tok_c = 2'b11;
         default: w_tok   = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_sym   <= '0;
         r_tok   <= 1'b0;
         r_tok_c <= 2'b00;
      end else begin
         r_sym   <= bus.tmds_in;
         r_tok   <= w_tok;
         r_tok_c <= w_tok_c;
      end
   end

   always_comb begin
      w_d      = r_sym[9] ? ~r_sym[7:0] : r_sym[7:0];
      w_dec    = '0;
      w_dec[0] = w_d[0];
      for (int i = 1; i < 8; i++) begin
         w_dec[i] = r_sym[8] ? (w_d[i] ^ w_d[i-1]) : ~(w_d[i] ^ w_d[i-1]);
      end
   end

   // A token arriving on the timeout cycle always wins over slip/unlock.
   assign w_to_hit      = (r_to_cnt == c_TO_LAST);
   assign w_lock        = (r_state == ST_SEARCH) && r_tok && (r_run_cnt == c_RUN_LAST);
   assign w_unlock      = (r_state == ST_LOCKED) && !r_tok && w_to_hit;
   assign w_aligned_nxt = w_lock || ((r_state == ST_LOCKED) && !w_unlock);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state   <= ST_SEARCH;
         r_run_cnt <= '0;
         r_to_cnt  <= '0;
         r_set_cnt <= '0;
         r_bitslip <= 1'b0;
         r_aligned <= 1'b0;
      end else begin
         r_bitslip <= 1'b0;
         r_aligned <= w_aligned_nxt;
         case (r_state)
            ST_SEARCH: begin
               if (w_lock) begin
                  r_state   <= ST_LOCKED;
                  r_run_cnt <= '0;
                  r_to_cnt  <= '0;
               end else if (!r_tok && w_to_hit) begin
                  r_state   <= ST_SLIP;
                  r_bitslip <= 1'b1;
                  r_run_cnt <= '0;
                  r_to_cnt  <= '0;
               end else begin
                  r_run_cnt <= r_tok ? r_run_cnt + 1'b1 : '0;
                  if (!w_to_hit) r_to_cnt <= r_to_cnt + 1'b1;
               end
            end
            ST_SLIP: begin
               r_state   <= ST_SETTLE;
               r_set_cnt <= '0;
            end
            ST_SETTLE: begin
               if (r_set_cnt == c_SET_LAST) begin
                  r_state   <= ST_SEARCH;
                  r_set_cnt <= '0;
               end else begin
                  r_set_cnt <= r_set_cnt + 1'b1;
               end
            end
            ST_LOCKED: begin
               if (r_tok) begin
                  r_to_cnt <= '0;
               end else if (w_to_hit) begin
                  r_state   <= ST_SEARCH;
                  r_to_cnt  <= '0;
                  r_run_cnt <= '0;
               end else begin
                  r_to_cnt <= r_to_cnt + 1'b1;
               end
            end
            default: r_state <= ST_SEARCH;
         endcase
      end
   end

   // Outputs are gated by next-cycle alignment so de/data never lead or lag aligned_out.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_data <= '0;
         r_de   <= 1'b0;
         r_c0   <= 1'b0;
         r_c1   <= 1'b0;
      end else if (w_aligned_nxt && r_tok) begin
         r_data <= '0;
         r_de   <= 1'b0;
         r_c0   <= r_tok_c[0];
         r_c1   <= r_tok_c[1];
      end else if (w_aligned_nxt) begin
         r_data <= w_dec;
         r_de   <= 1'b1;
      end else begin
         r_data <= '0;
         r_de   <= 1'b0;
      end
   end

`ifdef TMDS_LOSS_CNT_EN
   logic [15:0] r_loss_cnt;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_loss_cnt <= '0;
      end else if (w_unlock && (r_loss_cnt != 16'hFFFF)) begin
         r_loss_cnt <= r_loss_cnt + 16'd1;
      end
   end

   assign bus.loss_cnt_out = r_loss_cnt;
`endif

   assign bus.bitslip_out = r_bitslip;
   assign bus.aligned_out = r_aligned;
   assign bus.data_out    = r_data;
   assign bus.de_out      = r_de;
   assign bus.c0_out      = r_c0;
   assign bus.c1_out      = r_c1;

endmodule

`default_nettype wire

// File: tb/tb_tmds_decoder.sv
// ============================================================================
// Module      : tb_tmds_decoder
// Description : Scoreboard bench for tmds_decoder with a behavioural lane model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tmds_decoder;

   localparam int c_CTRL_RUN = 16;
   localparam int c_TIMEOUT  = 2048;
   localparam int c_SETTLE   = 16;

   // {loss[15:0], aligned, bitslip, de, c1, c0, data[7:0]}
   typedef logic [28:0] obs_t;

   logic clk  = 1'b0;
   logic rstn = 1'b1;

   tmds_decoder_if bus();

   tmds_decoder #(
      .CTRL_RUN       (c_CTRL_RUN),
      .SEARCH_TIMEOUT (c_TIMEOUT),
      .SLIP_SETTLE    (c_SETTLE)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int   checks = 0;
   int   fails  = 0;
   obs_t exp_q[$];
   bit   mon_en = 1'b0;
   int   cyc    = 0;

   // Lane model state
   bit        m_locked;
   int        m_run, m_age, m_quiet, m_hold, m_loss;
   logic [1:0] m_c;

   int rot = 0, slips = 0, last_slip = -1, min_gap = 1 << 30;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, expv);
      end
   endtask

   function automatic int tok_code(input logic [9:0] s);
      case (s)
         10'h354: return 0;
         10'h0AB: return 1;
         10'h154: return 2;
         10'h2AB: return 3;
         default: return -1;
      endcase
   endfunction

   function automatic logic [7:0] ref_decode(input logic [9:0] s);
      logic [7:0] d;
      d = s[9] ? ~s[7:0] : s[7:0];
      return d ^ (d << 1) ^ (s[8] ? 8'h00 : 8'hFE);
   endfunction

   function automatic logic [9:0] rotl(input logic [9:0] v, input int k);
      logic [19:0] w;
      w = {v, v} << k;
      return w[19:10];
   endfunction

   function automatic obs_t observed();
      obs_t o;
      o = '0;
`ifdef TMDS_LOSS_CNT_EN
      o[28:13] = bus.loss_cnt_out;
`endif
      o[12:0] = {bus.aligned_out, bus.bitslip_out, bus.de_out, bus.c1_out,
                 bus.c0_out, bus.data_out};
      return o;
   endfunction

   function automatic void model_reset();
      m_locked = 1'b0;
      m_run = 0; m_age = 0; m_quiet = 0; m_hold = 0; m_loss = 0;
      m_c = 2'b00;
   endfunction

   // One pixel clock of the lane, consuming the symbol held in the input register.
   function automatic obs_t model_step(input logic [9:0] s);
      obs_t o;
      int   code;
      bit   slip;
      code = tok_code(s);
      slip = 1'b0;
      if (m_hold > 0) begin
         m_hold--;
      end else if (m_locked) begin
         if (code >= 0) m_quiet = 0;
         else if (m_quiet == c_TIMEOUT - 1) begin
            m_locked = 1'b0; m_age = 0; m_run = 0;
            if (m_loss < 16'hFFFF) m_loss++;
         end else m_quiet++;
      end else begin
         if (code >= 0 && m_run == c_CTRL_RUN - 1) begin
            m_locked = 1'b1; m_quiet = 0;
         end else if (code < 0 && m_age == c_TIMEOUT - 1) begin
            slip = 1'b1; m_hold = c_SETTLE + 1; m_age = 0; m_run = 0;
         end else begin
            m_run = (code >= 0) ? m_run + 1 : 0;
            if (m_age < c_TIMEOUT - 1) m_age++;
         end
      end
      o = '0;
`ifdef TMDS_LOSS_CNT_EN
      o[28:13] = 16'(m_loss);
`endif
      o[12] = m_locked;
      o[11] = slip;
      if (m_locked && code >= 0) m_c = 2'(code);
      if (m_locked && code < 0) begin
         o[10]  = 1'b1;
         o[7:0] = ref_decode(s);
      end
      o[9:8] = m_c;
      return o;
   endfunction

   initial forever begin
      @(negedge clk);
      if (mon_en) begin
         if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL scoreboard_empty @%0t: got output with no expectation", $time);
         end else begin
            check("scoreboard", 32'(observed()), 32'(exp_q.pop_front()));
         end
      end
   end

   task automatic send(input logic [9:0] s, input bit use_rot);
      @(posedge clk);
      #2;
      if (bus.bitslip_out) begin
         slips++;
         if (last_slip >= 0 && (cyc - last_slip) < min_gap) min_gap = cyc - last_slip;
         last_slip = cyc;
         if (rot > 0) rot--;
      end
      bus.tmds_in = use_rot ? rotl(10'h354, rot) : s;
      exp_q.push_back(model_step(bus.tmds_in));
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      mon_en = 1'b0;
      rstn   = 1'b0;
      #1;
      check("reset_outputs", 32'(observed()), 32'h0);
      exp_q.delete();
   endtask

   task automatic release_reset(input logic [9:0] s);
      @(posedge clk);
      #2;
      rstn        = 1'b1;
      bus.tmds_in = s;
      model_reset();
      exp_q.push_back('0);
      exp_q.push_back(model_step(10'h000));
      exp_q.push_back(model_step(s));
      mon_en = 1'b1;
   endtask

   task automatic lock_latency(input string name);
      int lat;
      lat = 1;
      while (lat < 100 && !bus.aligned_out) begin
         send(10'h354, 1'b0);
         if (!bus.aligned_out) lat++;
      end
      check(name, 32'(lat), 32'd17);
   endtask

   initial begin
      int n;
      logic [9:0] s;
      bus.tmds_in = '0;
      #1 rstn = 1'b0;
      #1 check("reset_initial", 32'(observed()), 32'h0);
      repeat (3) @(posedge clk);

      // Clean lock on a stream of 0x354
      slips = 0;
      release_reset(10'h354);
      lock_latency("lock_latency");
      check("no_slip_clean_lock", 32'(slips), 32'd0);
      check("ctrl_after_lock", {29'd0, bus.c1_out, bus.c0_out, bus.de_out}, 32'd0);
      repeat (4) send(10'h354, 1'b0);

      // Stream rotated by 3 bits, un-rotated one bit per slip pulse
      do_reset();
      slips = 0; last_slip = -1; min_gap = 1 << 30; rot = 3;
      release_reset(rotl(10'h354, rot));
      n = 0;
      while (n < 10000 && !bus.aligned_out) begin
         send(10'h000, 1'b1);
         n++;
      end
      check("slip_count", 32'(slips), 32'd3);
      check("slip_spacing_ok", 32'(min_gap >= c_TIMEOUT + c_SETTLE + 1), 32'd1);
      check("lock_after_slips", 32'(bus.aligned_out), 32'd1);

      // Directed data and control symbols while locked
      send(10'h001, 1'b0);
      send(10'h2FE, 1'b0);
      send(10'h0AB, 1'b0);
      send(10'h154, 1'b0);
      send(10'h2AB, 1'b0);
      send(10'h354, 1'b0);

      // Random mix of tokens and data while locked
      repeat (600) begin
         if ($urandom_range(0, 9) < 5) begin
            case ($urandom_range(0, 3))
               0: s = 10'h354;
               1: s = 10'h0AB;
               2: s = 10'h154;
               default: s = 10'h2AB;
            endcase
         end else begin
            s = 10'($urandom_range(0, 1023));
         end
         send(s, 1'b0);
      end
      send(10'h2AB, 1'b0);

      // Loss of lock after a full timeout of data symbols
      repeat (c_TIMEOUT + 3) begin
         do s = 10'($urandom_range(0, 1023)); while (tok_code(s) >= 0);
         send(s, 1'b0);
      end
      check("unlock_aligned", 32'(bus.aligned_out), 32'd0);
      check("unlock_de", 32'(bus.de_out), 32'd0);
`ifdef TMDS_LOSS_CNT_EN
      check("loss_cnt", 32'(bus.loss_cnt_out), 32'd1);
`endif

      // Relock, then reset mid-lock and relock without slipping
      repeat (20) send(10'h154, 1'b0);
      check("relock", 32'(bus.aligned_out), 32'd1);
      do_reset();
      slips = 0;
      release_reset(10'h354);
      lock_latency("relock_latency");
      repeat (4) send(10'h354, 1'b0);
      check("no_slip_after_reset", 32'(slips), 32'd0);

      @(negedge clk);
      @(negedge clk);
      mon_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
